param_stack: RTL and testbench

Parametrised LIFO register stack with registered push/pop, full/empty status, sticky overflow/underflow flags and a flattened view of every entry for direct display on LEDs or a seven-segment driver. It is the general-purpose successor to the fixed 4×4 lab stack: it has configurable width and depth, a clock-edge interface, a push+pop replace-top operation, an occupancy count and software-clearable error flags. It sits between a debounced switch/button front end and the board display logic.

---
 rtl/param_stack.sv | 103 ++++++++++
 tb/tb_param_stack.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
`default_nettype none
// ============================================================================
// Module  : param_stack
// Brief   : Parametrised LIFO register stack with sticky over/underflow flags
//           and a flattened view of every entry.
// Revision: 1.0 - initial release
// ============================================================================
module param_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr_err,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       top,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic                   over,
  output logic                   under,
  output logic [WIDTH*DEPTH-1:0] contents
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_over;
  logic             r_under;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_replace;
  logic w_pop;
  logic w_set_over;
  logic w_set_under;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Push+pop on an empty stack degenerates to a plain push.
  assign w_push      = push && (!pop || w_empty) && !w_full;
  assign w_replace   = push && pop && !w_empty;
  assign w_pop       = pop && !push && !w_empty;
  assign w_set_over  = push && !pop && w_full;
  assign w_set_under = pop && !push && w_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_push) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  // A flag being set in the same cycle takes priority over clr_err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_over  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      if (w_set_over)   r_over <= 1'b1;
      else if (clr_err) r_over <= 1'b0;
      if (w_set_under)  r_under <= 1'b1;
      else if (clr_err) r_under <= 1'b0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_mem[i] <= '0;
      end else if (w_push && r_count == CW'(i)) begin
        r_mem[i] <= din;
      end else if (w_replace && r_count == CW'(i + 1)) begin
        r_mem[i] <= din;
      end else if (w_pop && r_count == CW'(i + 1)) begin
        r_mem[i] <= '0;
      end
    end
    assign contents[i*WIDTH +: WIDTH] = r_mem[i];
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_count == CW'(i + 1)) top = r_mem[i];
    end
  end

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;
  assign over  = r_over;
  assign under = r_under;

endmodule
`default_nettype wire

// File: tb/tb_param_stack.sv
`default_nettype none
// ============================================================================
// Module  : tb_param_stack
// Brief   : Directed checks of a 4x4 stack plus fill and random run of 8x7.
// Revision: 1.0 - initial release
// ============================================================================
module tb_param_stack;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        push4 = 0, pop4 = 0, clr4 = 0;
  logic [3:0]  din4 = '0;
  logic [3:0]  top4;
  logic [2:0]  count4;
  logic        full4, empty4, over4, under4;
  logic [15:0] cont4;

  logic        push8 = 0, pop8 = 0, clr8 = 0;
  logic [7:0]  din8 = '0;
  logic [7:0]  top8;
  logic [2:0]  count8;
  logic        full8, empty8, over8, under8;
  logic [55:0] cont8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_stack #(.WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .push(push4), .pop(pop4), .clr_err(clr4), .din(din4),
    .top(top4), .count(count4), .full(full4), .empty(empty4),
    .over(over4), .under(under4), .contents(cont4)
  );

  param_stack #(.WIDTH(8), .DEPTH(7)) dut8 (
    .clk(clk), .rst(rst), .push(push8), .pop(pop8), .clr_err(clr8), .din(din8),
    .top(top8), .count(count8), .full(full8), .empty(empty8),
    .over(over8), .under(under8), .contents(cont8)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply one operation to the 4x4 stack, then sample 1 ns after the edge.
  task automatic op4(input logic p, input logic q, input logic c, input logic [3:0] d);
    push4 = p; pop4 = q; clr4 = c; din4 = d;
    @(posedge clk); #1;
    push4 = 0; pop4 = 0; clr4 = 0;
  endtask

  task automatic op8(input logic p, input logic q, input logic c, input logic [7:0] d);
    push8 = p; pop8 = q; clr8 = c; din8 = d;
    @(posedge clk); #1;
    push8 = 0; pop8 = 0; clr8 = 0;
  endtask

  logic [7:0]  m [7];
  int          mcnt;
  logic        mov, mun;
  logic [55:0] mcont;
  logic [7:0]  mtop;

  task automatic model8(input logic p, input logic q, input logic c, input logic [7:0] d);
    logic so, su;
    so = 0; su = 0;
    if (p && q) begin
      if (mcnt == 0) begin m[0] = d; mcnt = 1; end
      else m[mcnt-1] = d;
    end else if (p) begin
      if (mcnt == 7) so = 1;
      else begin m[mcnt] = d; mcnt++; end
    end else if (q) begin
      if (mcnt == 0) su = 1;
      else begin mcnt--; m[mcnt] = '0; end
    end
    mov = so ? 1'b1 : (c ? 1'b0 : mov);
    mun = su ? 1'b1 : (c ? 1'b0 : mun);
    for (int i = 0; i < 7; i++) mcont[i*8 +: 8] = m[i];
    mtop = (mcnt == 0) ? 8'h00 : m[mcnt-1];
  endtask

  initial begin
    @(posedge clk); #1;
    check("rst_top", top4, 0);
    check("rst_count", count4, 0);
    check("rst_full", full4, 0);
    check("rst_empty", empty4, 1);
    check("rst_over", over4, 0);
    check("rst_under", under4, 0);
    check("rst_contents", cont4, 0);
    rst = 1;

    op4(1, 0, 0, 4'h3); check("push1_count", count4, 1);
    op4(1, 0, 0, 4'h5); check("push2_count", count4, 2);
    op4(1, 0, 0, 4'h9); check("push3_count", count4, 3);
    check("push3_full", full4, 0);
    op4(1, 0, 0, 4'hC); check("push4_count", count4, 4);
    check("push4_full", full4, 1);
    check("push4_top", top4, 4'hC);
    check("push4_contents", cont4, 16'hC953);

    op4(1, 0, 0, 4'h1);
    check("ovf_over", over4, 1);
    check("ovf_contents", cont4, 16'hC953);
    check("ovf_count", count4, 4);
    op4(0, 1, 0, 0); check("pop1_top", top4, 4'h9);
    check("pop1_contents", cont4, 16'h0953);
    op4(0, 1, 0, 0); check("pop2_top", top4, 4'h5);
    op4(0, 1, 0, 0); check("pop3_top", top4, 4'h3);
    op4(0, 1, 0, 0); check("pop4_top", top4, 0);
    check("pop4_empty", empty4, 1);
    check("pop4_contents", cont4, 0);
    check("pop4_over_sticky", over4, 1);
    op4(0, 0, 1, 0); check("clr_over", over4, 0);

    op4(0, 1, 0, 0);
    check("udf_under", under4, 1);
    check("udf_count", count4, 0);
    op4(0, 0, 1, 0); check("clr_under", under4, 0);
    op4(0, 1, 1, 0); check("udf_clr_same", under4, 1);
    op4(0, 0, 1, 0);

    op4(1, 0, 0, 4'h3);
    op4(1, 0, 0, 4'h5);
    op4(1, 1, 0, 4'hA);
    check("repl_count", count4, 2);
    check("repl_top", top4, 4'hA);
    check("repl_contents", cont4, 16'h00A3);
    op4(0, 1, 0, 0);
    op4(0, 1, 0, 0);
    op4(1, 1, 0, 4'h7);
    check("pp_empty_count", count4, 1);
    check("pp_empty_top", top4, 4'h7);
    check("pp_empty_under", under4, 0);
    op4(0, 1, 0, 0);

    op4(0, 1, 0, 0);
    op4(1, 0, 0, 4'h1);
    op4(1, 0, 0, 4'h2);
    op4(1, 0, 0, 4'h3);
    rst = 0;
    op4(1, 0, 0, 4'h4);
    check("midrst_count", count4, 0);
    check("midrst_contents", cont4, 0);
    check("midrst_under", under4, 0);
    check("midrst_over", over4, 0);
    check("midrst_empty", empty4, 1);
    rst = 1;
    op4(1, 0, 0, 4'h6);
    check("post_rst_contents", cont4, 16'h0006);
    check("post_rst_count", count4, 1);

    check("w8_rst_empty", empty8, 1);
    mcnt = 0; mov = 0; mun = 0;
    for (int i = 0; i < 7; i++) m[i] = '0;
    for (int i = 0; i < 7; i++) begin
      model8(1, 0, 0, 8'(i * 17 + 1));
      op8(1, 0, 0, 8'(i * 17 + 1));
    end
    check("w8_fill_count", count8, 7);
    check("w8_fill_full", full8, 1);
    check("w8_fill_contents", cont8, 56'h67_56_45_34_23_12_01);
    model8(1, 0, 0, 8'hEE);
    op8(1, 0, 0, 8'hEE);
    check("w8_over", over8, 1);
    check("w8_over_count", count8, 7);

    for (int k = 0; k < 1000; k++) begin
      logic p, q, c;
      logic [7:0] d;
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 15) == 0);
      d = 8'($urandom);
      model8(p, q, c, d);
      op8(p, q, c, d);
      check("rand_count", count8, mcnt);
      check("rand_top", top8, mtop);
      check("rand_contents", cont8, mcont);
      check("rand_flags", {full8, empty8, over8, under8},
            {mcnt == 7, mcnt == 0, mov, mun});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
